// File: rtl/mux_8_1_tdm_v.sv
// Time-division 8:1 multiplexer: captures a parallel byte and presents it one bit
// per slot (bit n in slot n) with the slot index alongside, for a 1:8 demux receiver.
module mux_8_1_tdm_v #(
    parameter int SLOT_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_code,
    input  logic       i_load,
    output logic       o_ready,
    output logic       o_a,
    output logic [2:0] o_sel_code,
    output logic       o_valid,
    output logic       o_done
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       shadow_reg, shadow_next;
    logic [CNT_W-1:0] slot_cnt_reg, slot_cnt_next;
    logic [2:0]       sel_reg, sel_next;

    logic             a_reg, a_next;
    logic [2:0]       sel_code_reg, sel_code_next;
    logic             valid_reg, valid_next;
    logic             done_reg, done_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            shadow_reg   <= '0;
            slot_cnt_reg <= '0;
            sel_reg      <= '0;
            a_reg        <= 1'b0;
            sel_code_reg <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shadow_reg   <= shadow_next;
            slot_cnt_reg <= slot_cnt_next;
            sel_reg      <= sel_next;
            a_reg        <= a_next;
            sel_code_reg <= sel_code_next;
            valid_reg    <= valid_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shadow_next   = shadow_reg;
        slot_cnt_next = slot_cnt_reg;
        sel_next      = sel_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_load) begin
                    state_next    = ST_SEND;
                    shadow_next   = i_code;
                    sel_next      = 3'd0;
                    slot_cnt_next = '0;
                end
            end
            ST_SEND: begin
                if (slot_cnt_reg == CNT_LAST) begin
                    slot_cnt_next = '0;
                    if (sel_reg == 3'd7) begin
                        state_next = ST_DONE;
                    end else begin
                        sel_next = sel_reg + 3'd1;
                    end
                end else begin
                    slot_cnt_next = slot_cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_comb begin
        valid_next    = (state_next == ST_SEND);
        done_next     = (state_next == ST_DONE);
        sel_code_next = valid_next ? sel_next : 3'd0;
        a_next        = valid_next ? shadow_next[sel_next] : 1'b0;
    end

    assign o_ready    = (state_reg == ST_IDLE);
    assign o_a        = a_reg;
    assign o_sel_code = sel_code_reg;
    assign o_valid    = valid_reg;
    assign o_done     = done_reg;

endmodule

// File: tb/tb_mux_8_1_tdm_v.sv
// Bench for mux_8_1_tdm_v: two instances (1 and 3 cycles per slot) checked every
// cycle against a queue of expected output records pushed when a load is accepted.
module tb_mux_8_1_tdm_v;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code;
    logic       load1, load3;
    logic       ready1, a1, valid1, done1;
    logic [2:0] sel1;
    logic       ready3, a3, valid3, done3;
    logic [2:0] sel3;

    always #5 clk = ~clk;

    mux_8_1_tdm_v #(.SLOT_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_code(code), .i_load(load1),
        .o_ready(ready1), .o_a(a1), .o_sel_code(sel1), .o_valid(valid1), .o_done(done1)
    );

    mux_8_1_tdm_v #(.SLOT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_code(code), .i_load(load3),
        .o_ready(ready3), .o_a(a3), .o_sel_code(sel3), .o_valid(valid3), .o_done(done3)
    );

    typedef struct packed {
        logic       ready;
        logic       valid;
        logic       a;
        logic       done;
        logic [2:0] sel;
    } obs_t;

    typedef struct {
        int unsigned d;    // 0: one cycle per slot, 1: three cycles per slot
        logic [7:0]  code;
        logic [7:0]  ser;  // expected serial bits, slot 0 in the MSB
    } vec_t;

    obs_t q1[$];
    obs_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t mk(input logic r, input logic v, input logic a,
                                input logic d, input logic [2:0] s);
        obs_t o;
        o.ready = r;
        o.valid = v;
        o.a     = a;
        o.done  = d;
        o.sel   = s;
        return o;
    endfunction

    // One record per cycle: 8 slots of sc cycles, one done cycle, one cycle back in idle.
    task automatic push_frame(input int unsigned d, input logic [7:0] ser);
        int sc;
        obs_t o;
        sc = (d == 0) ? 1 : 3;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < sc; c++) begin
                o = mk(1'b0, 1'b1, ser[7-k], 1'b0, 3'(k));
                if (d == 0) q1.push_back(o); else q3.push_back(o);
            end
        end
        o = mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        if (d == 0) q1.push_back(o); else q3.push_back(o);
        o = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        if (d == 0) q1.push_back(o); else q3.push_back(o);
    endtask

    task automatic check(input int unsigned d, input string tag);
        obs_t act, exp;
        exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        if (d == 0) begin
            act = mk(ready1, valid1, a1, done1, sel1);
            if (q1.size() > 0) exp = q1.pop_front();
        end else begin
            act = mk(ready3, valid3, a3, done3, sel3);
            if (q3.size() > 0) exp = q3.pop_front();
        end
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s sc%0d @%0t: got rdy=%b vld=%b sel=%0d a=%b done=%b, want rdy=%b vld=%b sel=%0d a=%b done=%b",
                     tag, (d == 0) ? 1 : 3, $time, act.ready, act.valid, act.sel, act.a, act.done,
                     exp.ready, exp.valid, exp.sel, exp.a, exp.done);
        end
    endtask

    // Called just after a falling edge: drive inputs, update the model, then check at the next falling edge.
    task automatic tick(input logic r, input logic l1, input logic l3,
                        input logic [7:0] c, input logic [7:0] ser, input string tag);
        rst   = r;
        load1 = l1;
        load3 = l3;
        code  = c;
        if (r) begin
            q1.delete();
            q3.delete();
        end else begin
            if (l1 && q1.size() == 0) push_frame(0, ser);
            if (l3 && q3.size() == 0) push_frame(1, ser);
        end
        @(negedge clk);
        check(0, tag);
        check(1, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q1.size() > 0 || q3.size() > 0); i++)
            tick(1'b0, 1'b0, 1'b0, code, 8'h00, tag);
        tick(1'b0, 1'b0, 1'b0, code, 8'h00, tag);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{d: 0, code: 8'hA5, ser: 8'b1010_0101};
        vecs[1] = '{d: 0, code: 8'h12, ser: 8'b0100_1000};
        vecs[2] = '{d: 1, code: 8'h81, ser: 8'b1000_0001};
        vecs[3] = '{d: 1, code: 8'h12, ser: 8'b0100_1000};
        vecs[4] = '{d: 0, code: 8'h01, ser: 8'b1000_0000};

        rst   = 1'b1;
        load1 = 1'b1;
        load3 = 1'b1;
        code  = 8'hFF;
        @(negedge clk);

        // Reset with load asserted, then the first edge after release captures 8'hFF.
        tick(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, "reset_vals");
        tick(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, "reset_vals");
        tick(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, "first_load");
        drain("first_frame");

        for (int i = 0; i < 5; i++) begin
            tick(1'b0, vecs[i].d == 0, vecs[i].d == 1, vecs[i].code, vecs[i].ser, "table_frame");
            drain("table_frame");
        end

        // Load pulse and new code during slot 3 must not disturb the 8'h3C frame.
        tick(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, "ignore_mid");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, "ignore_mid");
        tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "ignore_mid");
        drain("ignore_mid");

        // Held load: frames must follow each other every 8*SLOT_CYCLES+2 cycles.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, "b2b_sc1");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "b2b_sc1");
        drain("b2b_sc1");
        for (int i = 0; i < 26; i++) tick(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, "b2b_sc3");
        for (int i = 0; i < 26; i++) tick(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "b2b_sc3");
        drain("b2b_sc3");

        // Asynchronous reset while slot 5 is on the line.
        tick(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, "rst_mid");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, "rst_mid");
        #2 rst = 1'b1;
        q1.delete();
        q3.delete();
        #1 check(0, "rst_mid_async");
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, "rst_mid_hold");
        tick(1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, "after_rst");
        drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
